// File: rtl/canon_pkg.sv
// Shared types, state encoding, tone period table and song contents for the note sequencer.
// Period values are tone half-periods at a 12 MHz clock; pitch p is MIDI note 44+p (p=25 is A4).
package canon_pkg;

    typedef logic [5:0] pitch_t;
    typedef logic [3:0] dur_t;

    typedef struct packed {
        pitch_t pitch;
        dur_t   dur;
    } note_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    localparam logic [15:0] PERIOD_LUT [64] = '{
        16'd0,
        16'd54545, 16'd51484, 16'd48594, 16'd45867, 16'd43293, 16'd40863,
        16'd38569, 16'd36404, 16'd34361, 16'd32433, 16'd30613, 16'd28894,
        16'd27273, 16'd25742, 16'd24297, 16'd22933, 16'd21646, 16'd20431,
        16'd19285, 16'd18202, 16'd17181, 16'd16216, 16'd15306, 16'd14447,
        16'd13636, 16'd12871, 16'd12148, 16'd11466, 16'd10823, 16'd10215,
        16'd9642,  16'd9101,  16'd8590,  16'd8108,  16'd7653,  16'd7224,
        16'd6818,  16'd6435,  16'd6074,  16'd5733,  16'd5411,  16'd5108,
        16'd4821,  16'd4550,  16'd4295,  16'd4054,  16'd3826,  16'd3612,
        16'd3409,  16'd3218,  16'd3037,  16'd2867,  16'd2706,  16'd2554,
        16'd2411,  16'd2275,  16'd2148,  16'd2027,  16'd1913,  16'd1806,
        16'd1705,  16'd1609,  16'd1519
    };

    // Song contents: a short opening phrase, then a rising filler pattern.
    function automatic note_t song_entry(input logic [5:0] addr);
        note_t n;
        case (addr)
            6'd0:    n = '{pitch: 6'd25, dur: 4'd1};
            6'd1:    n = '{pitch: 6'd0,  dur: 4'd3};
            6'd2:    n = '{pitch: 6'd29, dur: 4'd0};
            6'd3:    n = '{pitch: 6'd32, dur: 4'd2};
            default: n = '{pitch: addr + 6'd10, dur: {2'b00, addr[1:0]}};
        endcase
        return n;
    endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM: one note per address, registered read with one cycle of latency.
module song_rom
    import canon_pkg::*;
(
    input  logic       clk,
    input  logic [5:0] addr,
    output note_t      data
);

    note_t data_q;
    note_t data_d;

    always_comb begin
        data_d = song_entry(addr);
    end

    // No reset so the table can map onto block RAM.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks the song ROM, hands each tone period to the tone generator and times notes.
// Optional macro NOTE_GAP_EN silences the gate during the final tick of multi-tick notes.
module note_sequencer
    import canon_pkg::*;
#(
    parameter int TICK_DIV = 1500000,
    parameter int SONG_LEN = 64,
    parameter int LOOP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] period,
    output logic        period_valid,
    input  logic        period_ready,
    output logic        gate,
    output logic        busy,
    output logic [5:0]  note_idx,
    output logic        done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [5:0]    IDX_LAST  = 6'(SONG_LEN - 1);

    state_t          state_q, state_d;
    logic [5:0]      note_idx_q, note_idx_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [4:0]      remain_q, remain_d;
    dur_t            dur_q, dur_d;
    logic            rest_q, rest_d;
    logic [15:0]     period_q, period_d;
    logic            period_valid_q, period_valid_d;
    logic            gate_q, gate_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    note_t           rom_note;

    // Addressing with the next index makes the entry available during FETCH,
    // so the period can be registered on the FETCH -> ISSUE edge.
    song_rom u_song_rom (
        .clk  (clk),
        .addr (note_idx_d),
        .data (rom_note)
    );

    always_comb begin
        state_d        = state_q;
        note_idx_d     = note_idx_q;
        tick_d         = tick_q;
        remain_d       = remain_q;
        dur_d          = dur_q;
        rest_d         = rest_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        gate_d         = gate_q;
        done_d         = 1'b0;

        if (stop) begin
            state_d        = S_IDLE;
            note_idx_d     = '0;
            tick_d         = '0;
            remain_d       = '0;
            period_valid_d = 1'b0;
            gate_d         = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    period_d       = PERIOD_LUT[rom_note.pitch];
                    dur_d          = rom_note.dur;
                    rest_d         = (rom_note.pitch == '0);
                    period_valid_d = 1'b1;
                    state_d        = S_ISSUE;
                end
                S_ISSUE: begin
                    if (period_ready) begin
                        period_valid_d = 1'b0;
                        tick_d         = '0;
                        remain_d       = {1'b0, dur_q} + 5'd1;
                        gate_d         = !rest_q;
                        state_d        = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d   = '0;
                        remain_d = remain_q - 5'd1;
`ifdef NOTE_GAP_EN
                        if (remain_q == 5'd2) begin
                            gate_d = 1'b0;
                        end
`endif
                        if (remain_q == 5'd1) begin
                            gate_d   = 1'b0;
                            remain_d = '0;
                            if (note_idx_q != IDX_LAST) begin
                                note_idx_d = note_idx_q + 6'd1;
                                state_d    = S_FETCH;
                            end else if (LOOP != 0) begin
                                note_idx_d = '0;
                                state_d    = S_FETCH;
                            end else begin
                                note_idx_d = '0;
                                done_d     = 1'b1;
                                state_d    = S_IDLE;
                            end
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            note_idx_q     <= '0;
            tick_q         <= '0;
            remain_q       <= '0;
            dur_q          <= '0;
            rest_q         <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            gate_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            note_idx_q     <= note_idx_d;
            tick_q         <= tick_d;
            remain_q       <= remain_d;
            dur_q          <= dur_d;
            rest_q         <= rest_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            gate_q         <= gate_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign gate         = gate_q;
    assign busy         = busy_q;
    assign note_idx     = note_idx_q;
    assign done         = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (LOOP=0 and LOOP=1) driven in parallel and compared
// every cycle against a cycle-countdown model of the song, plus directed scenario checks.
module tb_note_sequencer;

    localparam int TD = 4;
    localparam int SL = 4;
`ifdef NOTE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        ready;
    logic [15:0] period_w [2];
    logic [1:0]  valid_w;
    logic [1:0]  gate_w;
    logic [1:0]  busy_w;
    logic [5:0]  idx_w [2];
    logic [1:0]  done_w;

    int checks = 0;
    int errors = 0;

    // Song as written down for this bench: pitch, duration and tone half-period.
    int song_pitch [SL] = '{25, 0, 29, 32};
    int song_dur   [SL] = '{1, 3, 0, 2};

    // Model state per instance (index = LOOP value of that instance).
    int m_phase  [2];   // 0 idle, 1 fetching, 2 offering period, 3 sounding
    int m_idx    [2];
    int m_left   [2];   // clock cycles still to sound, including the current one
    int m_pitch  [2];
    int m_dur    [2];
    int m_period [2];
    bit m_valid  [2];
    bit m_done   [2];

    always #5 clk = ~clk;

    note_sequencer #(.TICK_DIV(TD), .SONG_LEN(SL), .LOOP(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period(period_w[0]), .period_valid(valid_w[0]), .period_ready(ready),
        .gate(gate_w[0]), .busy(busy_w[0]), .note_idx(idx_w[0]), .done(done_w[0])
    );

    note_sequencer #(.TICK_DIV(TD), .SONG_LEN(SL), .LOOP(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .period(period_w[1]), .period_valid(valid_w[1]), .period_ready(ready),
        .gate(gate_w[1]), .busy(busy_w[1]), .note_idx(idx_w[1]), .done(done_w[1])
    );

    function automatic int period_of(input int pitch);
        case (pitch)
            25:      return 13636;
            29:      return 10823;
            32:      return 9101;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_gate(input int i);
        return (m_phase[i] == 3) && (m_pitch[i] != 0) &&
               !(GAP && (m_dur[i] >= 1) && (m_left[i] <= TD));
    endfunction

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h t=%0t", tag, inst, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_idx[i] = 0; m_left[i] = 0; m_pitch[i] = 0;
            m_dur[i] = 0; m_period[i] = 0; m_valid[i] = 1'b0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (stop) begin
                m_phase[i] = 0; m_idx[i] = 0; m_valid[i] = 1'b0; m_left[i] = 0;
            end else begin
                case (m_phase[i])
                    0: if (start) m_phase[i] = 1;
                    1: begin
                        m_pitch[i]  = song_pitch[m_idx[i]];
                        m_dur[i]    = song_dur[m_idx[i]];
                        m_period[i] = period_of(m_pitch[i]);
                        m_valid[i]  = 1'b1;
                        m_phase[i]  = 2;
                    end
                    2: if (ready) begin
                        m_valid[i] = 1'b0;
                        m_left[i]  = (m_dur[i] + 1) * TD;
                        m_phase[i] = 3;
                    end
                    default: begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            if (m_idx[i] < SL - 1) begin
                                m_idx[i]++; m_phase[i] = 1;
                            end else if (i == 1) begin
                                m_idx[i] = 0; m_phase[i] = 1;
                            end else begin
                                m_idx[i] = 0; m_phase[i] = 0; m_done[i] = 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            chk("period",       i, 32'(period_w[i]), 32'(m_period[i]));
            chk("period_valid", i, 32'(valid_w[i]),  32'(m_valid[i]));
            chk("gate",         i, 32'(gate_w[i]),   32'(exp_gate(i)));
            chk("busy",         i, 32'(busy_w[i]),   32'(m_phase[i] != 0));
            chk("note_idx",     i, 32'(idx_w[i]),    32'(m_idx[i]));
            chk("done",         i, 32'(done_w[i]),   32'(m_done[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!valid_w[0] && n < bound) begin
            step();
            n++;
        end
        chk("wait_valid", 0, 32'(valid_w[0]), 32'd1);
    endtask

    initial begin
        int cnt;
        int dones;
        int n;
        bit wrapped;
        int prev_idx_b;

        rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b1;
        model_reset();
        #1;
        chk("reset_busy", 0, 32'(busy_w[0]), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        $display("reset: outputs idle, checks=%0d", checks);

        // First note: A4 for two ticks.
        start = 1'b1; step(); start = 1'b0;
        chk("valid_1cyc", 0, 32'(valid_w[0]), 32'd0);
        step();
        chk("valid_2cyc", 0, 32'(valid_w[0]), 32'd1);
        chk("a4_period",  0, 32'(period_w[0]), 32'd13636);
        cnt = 0;
        repeat (9) begin step(); cnt += int'(gate_w[0]); end
        chk("a4_gate_cycles", 0, 32'(cnt), GAP ? 32'd4 : 32'd8);
        $display("note0: A4 gate high %0d cycles", cnt);

        // Rest entry.
        wait_valid(10);
        chk("rest_period", 0, 32'(period_w[0]), 32'd0);
        cnt = 0;
        repeat (16) begin step(); cnt += int'(gate_w[0]); end
        chk("rest_gate_cycles", 0, 32'(cnt), 32'd0);
        $display("note1: rest gate high %0d cycles", cnt);

        // Back-pressure on the third entry.
        wait_valid(10);
        ready = 1'b0;
        repeat (5) begin
            step();
            chk("stall_valid",  0, 32'(valid_w[0]),  32'd1);
            chk("stall_period", 0, 32'(period_w[0]), 32'd10823);
        end
        ready = 1'b1;
        step();
        chk("play_after_ready_valid", 0, 32'(valid_w[0]), 32'd0);
        chk("play_after_ready_gate",  0, 32'(gate_w[0]),  32'd1);
        $display("note2: stalled 5 cycles, play started after ready");

        // Song end: one done pulse on the LOOP=0 instance, wrap on LOOP=1.
        dones = 0; wrapped = 1'b0; prev_idx_b = int'(idx_w[1]); n = 0;
        while (busy_w[0] && n < 60) begin
            step();
            dones += int'(done_w[0]);
            if (prev_idx_b == 3 && idx_w[1] == 6'd0 && busy_w[1]) wrapped = 1'b1;
            prev_idx_b = int'(idx_w[1]);
            n++;
        end
        chk("song_end_busy", 0, 32'(busy_w[0]), 32'd0);
        repeat (5) begin step(); dones += int'(done_w[0]); end
        chk("done_pulses", 0, 32'(dones), 32'd1);
        chk("loop_wrap",   1, 32'(wrapped), 32'd1);
        chk("loop_busy",   1, 32'(busy_w[1]), 32'd1);
        $display("song end: done pulses=%0d loop wrapped=%0d", dones, wrapped);

        // Stop during a sounding note.
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!gate_w[0] && n < 10) begin step(); n++; end
        chk("stop_pre_gate", 0, 32'(gate_w[0]), 32'd1);
        stop = 1'b1; step(); stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stop_busy", i, 32'(busy_w[i]), 32'd0);
            chk("stop_gate", i, 32'(gate_w[i]), 32'd0);
            chk("stop_idx",  i, 32'(idx_w[i]),  32'd0);
        end
        $display("stop mid-play: both instances idle");

        // Start and stop together: stop wins.
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", 0, 32'(busy_w[0]), 32'd0);
        chk("start_stop_busy", 1, 32'(busy_w[1]), 32'd0);
        step();
        $display("start+stop: stayed idle");

        // Asynchronous reset between clock edges while a note sounds.
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (!gate_w[0] && n < 10) begin step(); n++; end
        chk("rst_pre_gate", 0, 32'(gate_w[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_gate",   i, 32'(gate_w[i]),   32'd0);
            chk("async_rst_busy",   i, 32'(busy_w[i]),   32'd0);
            chk("async_rst_period", i, 32'(period_w[i]), 32'd0);
            chk("async_rst_valid",  i, 32'(valid_w[i]),  32'd0);
            chk("async_rst_idx",    i, 32'(idx_w[i]),    32'd0);
            chk("async_rst_done",   i, 32'(done_w[i]),   32'd0);
        end
        model_reset();
        step(); step();
        rst = 1'b0;
        step();
        $display("async reset mid-play: outputs cleared without a clock edge");

        // Randomized traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 99) == 0);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        start = 1'b0; stop = 1'b0; ready = 1'b1;
        step();
        $display("random: 2500 cycles compared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
